// File: rtl/keccak_pkg.sv
// Shared Keccak permutation constants and types.
// The rho offset table and FSM state type are reused by later fused steps.
package keccak_pkg;

   localparam int MAX_LANE_SIZE = 64;

   // Standard rho offsets, indexed [x][y].
   localparam int RHO_OFFSETS [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } rho_state_e;

   typedef logic [MAX_LANE_SIZE-1:0] lane_max_t;

   function automatic int rho_off_width(input int lane_size);
      return (lane_size > 1) ? $clog2(lane_size) : 1;
   endfunction

   function automatic int rho_eff_offset(input int x, input int y, input int lane_size);
      return RHO_OFFSETS[x][y] % lane_size;
   endfunction

endpackage

// File: rtl/rho_step_seq_lane_rotator.sv
// Combinational rotator for one lane: dir=0 rotates left, dir=1 rotates right.
// Wrap-around of the source bit index falls out of the offset-width arithmetic.
module lane_rotator
   import keccak_pkg::*;
#(
   parameter int LANE_SIZE = 64,
   localparam int OFF_W = rho_off_width(LANE_SIZE)
) (
   input  logic [LANE_SIZE-1:0] lane,
   input  logic [OFF_W-1:0]     offset,
   input  logic                 dir,
   output logic [LANE_SIZE-1:0] rotated
);

   // Per-bit source select; an offset of 0 selects each bit onto itself
   always_comb begin
      logic [OFF_W-1:0] src_s;
      rotated = '0;
      src_s   = '0;
      for (int b = 0; b < LANE_SIZE; b++) begin
         if (dir) begin
            src_s = OFF_W'(b) + offset;
         end else begin
            src_s = OFF_W'(b) - offset;
         end
         rotated[b] = lane[src_s];
      end
   end

endmodule

// File: rtl/rho_step_seq.sv
// Sequential Keccak rho (or inverse rho) over a full 5x5 state,
// rotating LANES_PER_CYCLE lanes per beat in a shared working register.
module rho_step_seq
   import keccak_pkg::*;
#(
   parameter int LANE_SIZE       = 64,
   parameter int LANES_PER_CYCLE = 5
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          inverse,
   input  logic [4:0][4:0][LANE_SIZE-1:0] state_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [4:0][4:0][LANE_SIZE-1:0] state_out,
   output logic                          busy
);

   localparam int NUM_BEATS = 25 / LANES_PER_CYCLE;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int OFF_W     = rho_off_width(LANE_SIZE);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   typedef logic [LANE_SIZE-1:0] lane_t;
   typedef logic [OFF_W-1:0]     off_t;

   rho_state_e       state_r;
   rho_state_e       state_next_s;
   logic [CNT_W-1:0] beat_r;
   logic             inv_r;
   lane_t            work_r    [25];
   off_t             off_tab_s [25];
   logic             load_s;
   logic             step_s;
   logic             in_ready_s;
   logic [4:0]       idx_s     [LANES_PER_CYCLE];
   lane_t            rot_in_s  [LANES_PER_CYCLE];
   off_t             rot_off_s [LANES_PER_CYCLE];
   lane_t            rot_out_s [LANES_PER_CYCLE];

   // Working register is kept flat by linear lane index 5x+y
   for (genvar j = 0; j < 25; j++) begin : g_lane
      assign off_tab_s[j]            = off_t'(rho_eff_offset(j / 5, j % 5, LANE_SIZE));
      assign state_out[j / 5][j % 5] = work_r[j];
   end

   for (genvar i = 0; i < LANES_PER_CYCLE; i++) begin : g_rot
      lane_rotator #(.LANE_SIZE(LANE_SIZE)) u_rot (
         .lane    (rot_in_s[i]),
         .offset  (rot_off_s[i]),
         .dir     (inv_r),
         .rotated (rot_out_s[i])
      );
   end

   // Select the lanes and offsets belonging to the current beat
   always_comb begin
      for (int i = 0; i < LANES_PER_CYCLE; i++) begin
         idx_s[i]     = 5'(int'(beat_r) * LANES_PER_CYCLE + i);
         rot_in_s[i]  = work_r[idx_s[i]];
         rot_off_s[i] = off_tab_s[idx_s[i]];
      end
   end

   // Next-state and handshake decode
   always_comb begin
      state_next_s = state_r;
      in_ready_s   = 1'b0;
      load_s       = 1'b0;
      step_s       = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready_s = 1'b1;
            if (in_valid) begin
               load_s       = 1'b1;
               state_next_s = BUSY;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            step_s = 1'b1;
            if (beat_r == LAST_BEAT) begin
               state_next_s = DONE;
            end else begin
               state_next_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               in_ready_s = 1'b1;
               if (in_valid) begin
                  load_s       = 1'b1;
                  state_next_s = BUSY;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = DONE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Beat counter, latched direction and in-place lane update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_r <= '0;
         inv_r  <= 1'b0;
         for (int j = 0; j < 25; j++) begin
            work_r[j] <= '0;
         end
      end else if (load_s) begin
         beat_r <= '0;
         inv_r  <= inverse;
         for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
               work_r[5 * x + y] <= state_in[x][y];
            end
         end
      end else if (step_s) begin
         for (int i = 0; i < LANES_PER_CYCLE; i++) begin
            work_r[idx_s[i]] <= rot_out_s[i];
         end
         if (beat_r == LAST_BEAT) begin
            beat_r <= '0;
         end else begin
            beat_r <= beat_r + CNT_W'(1);
         end
      end else begin
         beat_r <= beat_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = (state_r == DONE);
   assign busy      = (state_r == BUSY);

endmodule

// File: tb/tb_rho_step_seq.sv
// Directed bench for rho_step_seq: three instances cover lane widths 64/8 and
// 5/1/25 lanes per beat against a bit-level reference rotation.
module tb_rho_step_seq;

   typedef logic [4:0][4:0][63:0] st_t;
   typedef struct {
      int          x;
      int          y;
      logic [63:0] val;
      logic        inv;
      logic [63:0] exp;
   } vec_t;

   localparam int OFFS [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   logic clk = 1'b0;
   logic rst_n;
   logic [2:0] in_valid, inverse, out_ready;
   logic [2:0] in_ready, out_valid, busy;
   st_t st_in [3];
   st_t out_a, out_b, out_c;
   logic [4:0][4:0][7:0] b_in, b_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rho_step_seq #(.LANE_SIZE(64), .LANES_PER_CYCLE(5)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .inverse(inverse[0]), .state_in(st_in[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .state_out(out_a), .busy(busy[0]));

   rho_step_seq #(.LANE_SIZE(8), .LANES_PER_CYCLE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .inverse(inverse[1]), .state_in(b_in), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .state_out(b_out), .busy(busy[1]));

   rho_step_seq #(.LANE_SIZE(64), .LANES_PER_CYCLE(25)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .inverse(inverse[2]), .state_in(st_in[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .state_out(out_c), .busy(busy[2]));

   always_comb begin
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            b_in[x][y]  = st_in[1][x][y][7:0];
            out_b[x][y] = {56'd0, b_out[x][y]};
         end
      end
   end

   function automatic st_t dut_out(input int id);
      case (id)
         0:       return out_a;
         1:       return out_b;
         default: return out_c;
      endcase
   endfunction

   function automatic st_t rho_model(input st_t s, input logic inv, input int w);
      st_t r = '0;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            int k = OFFS[x][y] % w;
            for (int b = 0; b < w; b++) begin
               int d = inv ? (b - k + w) % w : (b + k) % w;
               r[x][y][d] = s[x][y][b];
            end
         end
      end
      return r;
   endfunction

   function automatic st_t rand_state(input int w);
      st_t r;
      for (int x = 0; x < 5; x++) begin
         for (int y = 0; y < 5; y++) begin
            r[x][y] = {$urandom, $urandom};
            if (w < 64) r[x][y] = r[x][y] & ((64'd1 << w) - 64'd1);
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_st(input string name, input st_t got, input st_t exp);
      bit shown = 1'b0;
      checks++;
      if (got !== exp) begin
         errors++;
         for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
               if (!shown && got[x][y] !== exp[x][y]) begin
                  shown = 1'b1;
                  $display("FAIL %s: lane[%0d][%0d] got %h expected %h",
                           name, x, y, got[x][y], exp[x][y]);
               end
            end
         end
      end
   endtask

   task automatic send(input int id, input st_t s, input logic inv);
      int n = 0;
      st_in[id] = s; inverse[id] = inv; in_valid[id] = 1'b1;
      while (!in_ready[id] && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      in_valid[id] = 1'b0;
      st_in[id]    = rand_state(64);
      inverse[id]  = ~inv;
   endtask

   task automatic recv(input int id, input bit ack, output st_t r, output int lat);
      bit bad = 1'b0;
      lat = 0;
      while (!out_valid[id] && lat < 100) begin
         if (in_ready[id] !== 1'b0 || busy[id] !== 1'b1) bad = 1'b1;
         @(posedge clk); #1; lat++;
      end
      chk("busy_blocks_input", 64'(bad), 64'd0);
      r = dut_out(id);
      if (ack) begin
         out_ready[id] = 1'b1;
         @(posedge clk); #1;
         out_ready[id] = 1'b0;
      end
   endtask

   initial begin
      vec_t vecs [10];
      st_t  s, e, r, f, s2;
      int   lat, cyc, got, sent;
      bit   acc, pop, bad;
      st_t  q [$];

      vecs[0] = '{1, 0, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0002};
      vecs[1] = '{2, 0, 64'h0000_0000_0000_0001, 1'b0, 64'h4000_0000_0000_0000};
      vecs[2] = '{1, 0, 64'h0000_0000_0000_0001, 1'b1, 64'h8000_0000_0000_0000};
      vecs[3] = '{0, 0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
      vecs[4] = '{0, 1, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0010_0000_0000};
      vecs[5] = '{4, 4, 64'h8000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_2000};
      vecs[6] = '{3, 4, 64'h0000_0000_0000_0003, 1'b1, 64'h0000_0000_0000_0300};
      vecs[7] = '{2, 1, 64'hF000_0000_0000_0000, 1'b0, 64'h0000_0000_0000_003C};
      vecs[8] = '{4, 0, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_0020_0000_0000};
      vecs[9] = '{3, 3, 64'h0000_0000_0000_0001, 1'b0, 64'h0000_0000_0020_0000};

      rst_n = 1'b0;
      in_valid = 3'b000; inverse = 3'b000; out_ready = 3'b000;
      for (int i = 0; i < 3; i++) st_in[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_st("reset_state_out", out_a, '0);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 64'(in_ready), 64'h7);

      // Two lanes, forward, LPC=5
      s = '0; s[1][0] = 64'h1; s[2][0] = 64'h1;
      e = '0; e[1][0] = 64'h2; e[2][0] = 64'h4000_0000_0000_0000;
      send(0, s, 1'b0);
      recv(0, 1'b1, r, lat);
      chk("a_latency", 64'(lat), 64'd5);
      chk_st("a_two_lanes", r, e);

      for (int i = 0; i < 10; i++) begin
         s = '0; s[vecs[i].x][vecs[i].y] = vecs[i].val;
         e = '0; e[vecs[i].x][vecs[i].y] = vecs[i].exp;
         send(0, s, vecs[i].inv);
         recv(0, 1'b1, r, lat);
         chk_st($sformatf("vec%0d", i), r, e);
      end

      // Random forward then inverse round trip
      s = rand_state(64);
      send(0, s, 1'b0);
      recv(0, 1'b1, f, lat);
      chk_st("a_fwd_model", f, rho_model(s, 1'b0, 64));
      send(0, f, 1'b1);
      recv(0, 1'b1, r, lat);
      chk_st("a_round_trip", r, s);

      // LANE_SIZE=8, one lane per beat
      s = '0; s[0][1] = 64'h01; s[2][0] = 64'h01;
      e = '0; e[0][1] = 64'h10; e[2][0] = 64'h40;
      send(1, s, 1'b0);
      recv(1, 1'b1, r, lat);
      chk("b_latency", 64'(lat), 64'd25);
      chk_st("b_two_lanes", r, e);
      s = rand_state(8);
      send(1, s, 1'b1);
      recv(1, 1'b1, r, lat);
      chk_st("b_inverse_model", r, rho_model(s, 1'b1, 8));

      // Backpressure in DONE, then same-cycle accept
      s  = rand_state(64);
      s2 = rand_state(64);
      send(0, s, 1'b0);
      recv(0, 1'b0, r, lat);
      e = rho_model(s, 1'b0, 64);
      chk_st("bp_result", r, e);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_a !== e || out_valid[0] !== 1'b1) bad = 1'b1;
      end
      chk("bp_hold_stable", 64'(bad), 64'd0);
      out_ready[0] = 1'b1; in_valid[0] = 1'b1; st_in[0] = s2; inverse[0] = 1'b1;
      #1;
      chk("bp_same_cycle_ready", 64'(in_ready[0]), 64'd1);
      @(posedge clk); #1;
      out_ready[0] = 1'b0; in_valid[0] = 1'b0; inverse[0] = 1'b0;
      chk("bp_reload_busy", 64'({out_valid[0], busy[0]}), 64'b01);
      recv(0, 1'b1, r, lat);
      chk("bp_latency", 64'(lat), 64'd5);
      chk_st("bp_second_result", r, rho_model(s2, 1'b1, 64));

      // LPC=25: single BUSY cycle
      s = '1;
      send(2, s, 1'b0);
      recv(2, 1'b1, r, lat);
      chk("c_latency", 64'(lat), 64'd1);
      chk_st("c_all_ones", r, s);

      // LPC=25: 1000 back-to-back random transactions
      q = {}; got = 0; sent = 0; cyc = 0;
      st_in[2] = rand_state(64); inverse[2] = 1'($urandom);
      in_valid[2] = 1'b1; out_ready[2] = 1'b1;
      while (got < 1000 && cyc < 6000) begin
         acc = in_valid[2] && in_ready[2];
         pop = out_valid[2];
         if (pop) begin
            if (q.size() == 0) begin
               chk("c_spurious_output", 64'd1, 64'd0);
            end else begin
               chk_st("c_b2b", out_c, q.pop_front());
            end
            got++;
         end
         if (acc) begin
            q.push_back(rho_model(st_in[2], inverse[2], 64));
            sent++;
         end
         @(posedge clk); #1; cyc++;
         if (acc) begin
            st_in[2] = rand_state(64); inverse[2] = 1'($urandom);
            if (sent == 1000) in_valid[2] = 1'b0;
         end
      end
      in_valid[2] = 1'b0; out_ready[2] = 1'b0;
      chk("c_b2b_count", 64'(got), 64'd1000);

      // Reset during beat 2
      s = rand_state(64);
      send(0, s, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_st("rst_mid_state_out", out_a, '0);
      chk("rst_mid_flags", 64'({out_valid[0], busy[0]}), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_release_ready", 64'(in_ready[0]), 64'd1);
      s = rand_state(64);
      send(0, s, 1'b1);
      recv(0, 1'b1, r, lat);
      chk("rst_after_latency", 64'(lat), 64'd5);
      chk_st("rst_after_result", r, rho_model(s, 1'b1, 64));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
